// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF stage with one-outstanding imem fetch, IF/ID slot and branch redirect (FETCH_STATS_EN adds fetch/redirect counters)
module pc_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            id_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [31:0]     redirect_count
`endif
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t state;
  logic [XLEN-1:0] pc;
  logic drop;
  logic consume;
  assign imem_req_valid = (state == S_REQ) & ~pc_src;
  assign imem_req_addr = pc;
  assign consume = if_valid & id_ready & ~stall;
  // fetch FSM: redirect outranks everything; a redirect while a response is pending marks it for discard
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      state <= S_REQ;
      drop <= 1'b0;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_instr <= 32'h0000_0013;
    end else if (pc_src) begin
      pc <= branch_target & ~XLEN'(3);
      if_valid <= 1'b0;
      drop <= (state == S_WAIT) & ~imem_rsp_valid;
      state <= ((state == S_WAIT) & ~imem_rsp_valid) ? S_WAIT : S_REQ;
    end else begin
      unique case (state)
        S_REQ: if (imem_req_ready) state <= S_WAIT;
        S_WAIT:
          if (imem_rsp_valid) begin
            if (drop) begin
              drop <= 1'b0;
              state <= S_REQ;
            end else begin
              if_instr <= imem_rsp_data;
              if_pc <= pc;
              if_valid <= 1'b1;
              pc <= pc + XLEN'(4);
              state <= S_HOLD;
            end
          end
        S_HOLD:
          if (consume) begin
            if_valid <= 1'b0;
            state <= S_REQ;
          end
        default: state <= S_REQ;
      endcase
    end
  end
`ifdef FETCH_STATS_EN
  // count slot consumes and redirect cycles, both wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
      redirect_count <= '0;
    end else begin
      fetch_count <= fetch_count + 32'(consume);
      redirect_count <= redirect_count + 32'(pc_src);
    end
  end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random checks of pc_fetch_unit against an epoch-based fetch model
module tb_pc_fetch_unit;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 0, rst_n = 0, pc_src = 0, stall = 0, imem_req_ready = 0, imem_rsp_valid = 0, id_ready = 0;
  logic [31:0] branch_target = 0, imem_rsp_data = 0;
  logic imem_req_valid, if_valid;
  logic [31:0] imem_req_addr, if_pc, if_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, redirect_count;
`endif
  always #5 clk = ~clk;
  pc_fetch_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
  );
  int asserts = 0, fails = 0, cyc = 0, lat = 0, m_cnt = 0, epoch = 0, o_tag = 0;
  bit armed = 0, o_v = 0, s_v = 0, last_acc = 0;
  logic [31:0] e_pc = RPC, s_pc = 0, s_instr = 32'h13, o_addr = 0, e_fc = 0, e_rc = 0, last_aa = 0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic step();
    bit acc, rsp, rn, ps, cons;
    logic [31:0] aa, tg;
    #1;
    if (armed) begin
      chk("if_valid", {31'b0, if_valid}, {31'b0, s_v});
      chk("if_pc", if_pc, s_pc);
      chk("if_instr", if_instr, s_instr);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, !o_v && !s_v && !pc_src});
      chk("req_addr", imem_req_addr, e_pc);
`ifdef FETCH_STATS_EN
      chk("fetch_count", fetch_count, e_fc);
      chk("redirect_count", redirect_count, e_rc);
`endif
    end
    acc = imem_req_valid && imem_req_ready;
    aa = imem_req_addr;
    rsp = imem_rsp_valid;
    rn = rst_n;
    ps = pc_src;
    tg = branch_target;
    cons = s_v && id_ready && !stall;
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc && rn;
    last_aa = aa;
    if (!rn) begin
      e_pc = RPC; s_v = 0; s_pc = 0; s_instr = 32'h13; o_v = 0; e_fc = 0; e_rc = 0; epoch++;
    end else begin
      if (cons) begin s_v = 0; e_fc++; end
      if (rsp) begin
        o_v = 0;
        if (o_tag == epoch && !ps) begin s_v = 1; s_pc = o_addr; s_instr = mem(o_addr); e_pc = o_addr + 4; end
      end
      if (ps) begin e_pc = tg & ~32'h3; s_v = 0; epoch++; e_rc++; end
      if (acc) begin o_v = 1; o_tag = epoch; o_addr = aa; m_cnt = lat; end
      else if (o_v && m_cnt > 0) m_cnt--;
    end
    imem_rsp_valid = o_v && m_cnt == 0;
    imem_rsp_data = o_v ? mem(o_addr) : 32'h0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    step();
    armed = 1;
    step();
    rst_n = 1;
  endtask
  task automatic wait_acc(input logic [31:0] a, input string tag);
    int n = 0;
    do begin step(); n++; end while (!(last_acc && last_aa == a) && n < 100);
    chk(tag, last_aa, a);
  endtask
  task automatic wait_req(input logic [31:0] a, input string tag);
    int n = 0;
    #1;
    while (!imem_req_valid && n < 100) begin step(); #1; n++; end
    chk({tag, "_seen"}, {31'b0, imem_req_valid}, 32'd1);
    chk(tag, imem_req_addr, a);
  endtask
  task automatic wait_slot(input logic [31:0] a, input string tag);
    int n = 0;
    while (!if_valid && n < 100) begin step(); n++; end
    chk({tag, "_seen"}, {31'b0, if_valid}, 32'd1);
    chk(tag, if_pc, a);
    chk({tag, "_instr"}, if_instr, mem(a));
  endtask
  initial begin
    logic [31:0] pcs[$];
    int cycs[$];
    // reset state, then back-to-back fetch spacing
    lat = 0; imem_req_ready = 1; id_ready = 1;
    do_reset();
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h13);
    chk("rst_req_addr", imem_req_addr, RPC);
    for (int i = 0; i < 12; i++) begin
      step();
      if (if_valid) begin pcs.push_back(if_pc); cycs.push_back(cyc); end
    end
    while (pcs.size() < 3) begin pcs.push_back(32'hDEAD); cycs.push_back(0); end
    chk("t1_pc0", pcs[0], 32'h100);
    chk("t1_pc1", pcs[1], 32'h104);
    chk("t1_pc2", pcs[2], 32'h108);
    chk("t1_gap1", 32'(cycs[1] - cycs[0]), 32'd3);
    chk("t1_gap2", 32'(cycs[2] - cycs[1]), 32'd3);
    // redirect while waiting on the 0x104 response
    lat = 3;
    do_reset();
    wait_acc(32'h104, "t2_acc");
    pc_src = 1; branch_target = 32'h2000;
    step();
    pc_src = 0;
    wait_req(32'h2000, "t2_req");
    wait_slot(32'h2000, "t2_slot");
`ifdef FETCH_STATS_EN
    chk("t2_redirects", redirect_count, 32'd1);
`endif
    // redirect in the same cycle as the response
    lat = 0;
    do_reset();
    wait_acc(32'h100, "t3_acc");
    pc_src = 1; branch_target = 32'h2400;
    step();
    pc_src = 0;
    wait_req(32'h2400, "t3_req");
    wait_slot(32'h2400, "t3_slot");
    // stall holds the slot and blocks new requests
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_v", {31'b0, if_valid}, 32'd1);
      chk("t4_hold_pc", if_pc, 32'h2400);
      chk("t4_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    stall = 0;
    step();
    chk("t4_consumed", {31'b0, if_valid}, 32'd0);
    // target alignment and PC wrap
    pc_src = 1; branch_target = 32'h3003;
    step();
    pc_src = 0;
    wait_req(32'h3000, "t5_align");
    pc_src = 1; branch_target = 32'hFFFF_FFFF;
    step();
    pc_src = 0;
    wait_req(32'hFFFF_FFFC, "t5_top");
    wait_slot(32'hFFFF_FFFC, "t5_slot");
    wait_req(32'h0, "t5_wrap");
    // reset while a response is outstanding
    lat = 3;
    wait_acc(32'h0, "t6_acc");
    rst_n = 0;
    step();
    rst_n = 1;
    chk("t6_if_valid", {31'b0, if_valid}, 32'd0);
    chk("t6_req_addr", imem_req_addr, RPC);
`ifdef FETCH_STATS_EN
    chk("t6_fc", fetch_count, 32'd0);
    chk("t6_rc", redirect_count, 32'd0);
`endif
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      lat = $urandom % 4;
      id_ready = ($urandom % 3) != 0;
      stall = ($urandom % 4) == 0;
      pc_src = ($urandom % 12) == 0;
      branch_target = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      rst_n = ($urandom % 400) != 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
